// File: rtl/decoder_nto2n_seq.sv
// decoder_nto2n_seq
//   Registered N-to-2^N one-hot decoder with active-high enable. Drives
//   glitch-free select/strobe or row-scan lines from flops only.
//
//   Optional feature macro: DECODER_SCAN_EN
//     defined   -> auto-scan mode (mode=1) walks the active line across all
//                  outputs, holding each index dwell+1 cycles, with load and
//                  a wrap pulse on the OUT_W-1 -> 0 advance.
//     undefined -> direct decode only; mode/load/dwell ignored, wrap tied 0,
//                  no dwell counter.
//
// Parameters
//   SEL_W   select width (1..6); OUT_W = 2**SEL_W is derived
//   DWELL_W width of the dwell count
// Ports
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset (priority over everything)
//   enab   output enable; 0 forces y to zero on the next edge
//   mode   0 = direct decode of inp, 1 = auto-scan
//   inp    direct select index / scan start index
//   load   scan: load inp as current index
//   dwell  scan: each index held dwell+1 cycles
//   y      registered one-hot output
//   idx    registered index currently driven
//   wrap   one-cycle pulse when the scan advances OUT_W-1 -> 0
module decoder_nto2n_seq #(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enab,
  input  logic                   mode,
  input  logic [SEL_W-1:0]       inp,
  input  logic                   load,
  input  logic [DWELL_W-1:0]     dwell,
  output logic [(2**SEL_W)-1:0]  y,
  output logic [SEL_W-1:0]       idx,
  output logic                   wrap
);

  localparam int OUT_W = 2**SEL_W;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DIRECT = 2'd1;
  localparam logic [1:0] SCAN   = 2'd2;

  logic [1:0] state;

`ifdef DECODER_SCAN_EN
  logic [DWELL_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      y     <= '0;
      idx   <= '0;
      cnt   <= '0;
      wrap  <= 1'b0;
    end else if (!enab) begin
      // idx is deliberately kept so a later scan resumes where it stopped
      state <= IDLE;
      y     <= '0;
      cnt   <= '0;
      wrap  <= 1'b0;
    end else if (!mode) begin
      state <= DIRECT;
      idx   <= inp;
      y     <= OUT_W'(1) << inp;
      cnt   <= '0;
      wrap  <= 1'b0;
    end else begin
      state <= SCAN;
      if (state != SCAN || load) begin
        // entry or explicit load: restart the dwell window on the new index
        cnt  <= '0;
        wrap <= 1'b0;
        if (load) begin
          idx <= inp;
          y   <= OUT_W'(1) << inp;
        end else begin
          y   <= OUT_W'(1) << idx;
        end
      end else if (cnt == dwell) begin
        // exact compare: a dwell lowered below cnt waits for cnt to roll over
        idx  <= idx + 1'b1;
        y    <= {y[OUT_W-2:0], y[OUT_W-1]};
        cnt  <= '0;
        wrap <= (idx == SEL_W'(OUT_W-1));
      end else begin
        cnt  <= cnt + 1'b1;
        wrap <= 1'b0;
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      y     <= '0;
      idx   <= '0;
    end else if (!enab) begin
      state <= IDLE;
      y     <= '0;
    end else begin
      state <= DIRECT;
      idx   <= inp;
      y     <= OUT_W'(1) << inp;
    end
  end

  assign wrap = 1'b0;

  // scan controls and the state register have no consumer in this build
  logic unused_scan;
  assign unused_scan = ^{mode, load, dwell, state};
`endif

endmodule

// File: tb/tb_decoder_nto2n_seq.sv
module tb_decoder_nto2n_seq;

  localparam int SEL_W   = 3;
  localparam int DWELL_W = 8;
  localparam int OUT_W   = 2**SEL_W;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               enab;
  logic               mode;
  logic [SEL_W-1:0]   inp;
  logic               load;
  logic [DWELL_W-1:0] dwell;
  logic [OUT_W-1:0]   y;
  logic [SEL_W-1:0]   idx;
  logic               wrap;

  int total = 0;
  int bad   = 0;

  decoder_nto2n_seq #(.SEL_W(SEL_W), .DWELL_W(DWELL_W)) dut (
    .clk(clk), .rst_n(rst_n), .enab(enab), .mode(mode), .inp(inp),
    .load(load), .dwell(dwell), .y(y), .idx(idx), .wrap(wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             enab;
    logic [SEL_W-1:0] inp;
    logic [OUT_W-1:0] exp_y;
    logic [SEL_W-1:0] exp_idx;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic [OUT_W-1:0] ey,
                         input logic [SEL_W-1:0] ei, input logic ew);
    chk({nm, ".y"},    32'(y),    32'(ey));
    chk({nm, ".idx"},  32'(idx),  32'(ei));
    chk({nm, ".wrap"}, 32'(wrap), 32'(ew));
  endtask

  vec_t vecs[12];

  initial begin
    // direct-mode vectors: applied, then checked one edge later
    vecs[0]  = '{1'b1, 3'd5, 8'b0010_0000, 3'd5};
    vecs[1]  = '{1'b0, 3'd1, 8'b0000_0000, 3'd5};
    vecs[2]  = '{1'b1, 3'd0, 8'b0000_0001, 3'd0};
    vecs[3]  = '{1'b1, 3'd1, 8'b0000_0010, 3'd1};
    vecs[4]  = '{1'b1, 3'd2, 8'b0000_0100, 3'd2};
    vecs[5]  = '{1'b1, 3'd3, 8'b0000_1000, 3'd3};
    vecs[6]  = '{1'b1, 3'd4, 8'b0001_0000, 3'd4};
    vecs[7]  = '{1'b1, 3'd5, 8'b0010_0000, 3'd5};
    vecs[8]  = '{1'b1, 3'd6, 8'b0100_0000, 3'd6};
    vecs[9]  = '{1'b1, 3'd7, 8'b1000_0000, 3'd7};
    vecs[10] = '{1'b0, 3'd3, 8'b0000_0000, 3'd7};
    vecs[11] = '{1'b1, 3'd7, 8'b1000_0000, 3'd7};

    rst_n = 1'b0; enab = 1'b0; mode = 1'b0; inp = '0; load = 1'b0; dwell = '0;
    step();
    step();
    chk_out("reset", 8'h00, 3'd0, 1'b0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      enab = vecs[i].enab;
      inp  = vecs[i].inp;
      step();
      chk_out($sformatf("direct[%0d]", i), vecs[i].exp_y, vecs[i].exp_idx, 1'b0);
    end

`ifdef DECODER_SCAN_EN
    begin
      logic [SEL_W-1:0] sidx[8];
      logic             swr[8];
      logic [SEL_W-1:0] gidx[4];
      // load 6 with dwell=2: 6 x3, 7 x3, then 0 with a single-cycle wrap
      sidx = '{3'd6, 3'd6, 3'd7, 3'd7, 3'd7, 3'd0, 3'd0, 3'd0};
      swr  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      enab = 1'b1; mode = 1'b1; load = 1'b1; inp = 3'd6; dwell = 8'd2;
      step();
      chk_out("scan_load6", 8'b0100_0000, 3'd6, 1'b0);
      load = 1'b0;
      for (int k = 0; k < 8; k++) begin
        step();
        chk_out($sformatf("scan[%0d]", k), 8'(1) << sidx[k], sidx[k], swr[k]);
      end

      // cnt == dwell here; load must win over the advance
      load = 1'b1; inp = 3'd3;
      step();
      chk_out("load_vs_adv", 8'b0000_1000, 3'd3, 1'b0);
      load = 1'b0;
      step();
      chk_out("load_hold", 8'b0000_1000, 3'd3, 1'b0);

      // enable gap at idx 4, then resume with a full dwell+1 hold
      load = 1'b1; inp = 3'd4;
      step();
      chk_out("load4", 8'b0001_0000, 3'd4, 1'b0);
      load = 1'b0; enab = 1'b0;
      for (int k = 0; k < 4; k++) begin
        step();
        chk_out($sformatf("gap[%0d]", k), 8'h00, 3'd4, 1'b0);
      end
      enab = 1'b1;
      gidx = '{3'd4, 3'd4, 3'd4, 3'd5};
      for (int k = 0; k < 4; k++) begin
        step();
        chk_out($sformatf("resume[%0d]", k), 8'(1) << gidx[k], gidx[k], 1'b0);
      end

      // dwell=0 advances every cycle, wrap only on 7 -> 0
      load = 1'b1; inp = 3'd7; dwell = 8'd0;
      step();
      chk_out("d0_load7", 8'b1000_0000, 3'd7, 1'b0);
      load = 1'b0;
      step();
      chk_out("d0_wrap", 8'b0000_0001, 3'd0, 1'b1);
      step();
      chk_out("d0_next", 8'b0000_0010, 3'd1, 1'b0);

      // load to 0 must not pulse wrap
      load = 1'b1; inp = 3'd0;
      step();
      chk_out("load0", 8'b0000_0001, 3'd0, 1'b0);
      load = 1'b0; dwell = 8'd5;
      step();

      // reset mid-scan
      rst_n = 1'b0;
      step();
      chk_out("rst_mid", 8'h00, 3'd0, 1'b0);
      rst_n = 1'b1;
    end
`else
    // scan controls are ignored: mode=1 behaves as plain direct decode
    enab = 1'b1; mode = 1'b1; dwell = 8'd0; inp = 3'd2;
    for (int k = 0; k < 6; k++) begin
      load = k[0];
      step();
      chk_out($sformatf("noscan[%0d]", k), 8'b0000_0100, 3'd2, 1'b0);
    end
    rst_n = 1'b0;
    step();
    chk_out("rst_mid", 8'h00, 3'd0, 1'b0);
    rst_n = 1'b1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
